sopc_run_ctrl: RTL and testbench

//  Parametrised run controller for multi-core openMIPS SOPC builds; successor to fixed-delay bench reset/stop sequencing.

---
 rtl/sopc_run_ctrl_pkg.sv | 20 ++
 rtl/run_cycle_counter.sv | 25 ++
 rtl/sopc_run_ctrl.sv | 132 +++++++++++++
 tb/tb_sopc_run_ctrl.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sopc_run_ctrl_pkg.sv
// Shared types and constants for the SOPC run controller.
// Reset level matches the openMIPS core convention (reset asserted high).
package sopc_run_ctrl_pkg;

    typedef enum logic [2:0] {
        RC_IDLE    = 3'd0,
        RC_HOLD    = 3'd1,
        RC_RELEASE = 3'd2,
        RC_RUN     = 3'd3,
        RC_DONE    = 3'd4
    } rc_state_e;

    localparam logic RST_ENABLE  = 1'b1;
    localparam logic RST_DISABLE = 1'b0;

    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating run-cycle counter with synchronous clear and a terminal-count compare.
module run_cycle_counter #(
    parameter int unsigned CNT_W    = 16,
    parameter bit          TERM_EN  = 1'b1,
    parameter int unsigned TERM_VAL = 49
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             term
);

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cnt <= '0;
        end else if (en && (cnt != '1)) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign term = TERM_EN && (cnt == CNT_W'(TERM_VAL));

endmodule

// File: rtl/sopc_run_ctrl.sv
// Run controller: holds core resets, releases enabled channels staggered,
// then runs until all enabled cores halt or the cycle budget expires.
module sopc_run_ctrl
    import sopc_run_ctrl_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned HOLD_CYCLES = 10,
    parameter int unsigned STAGGER     = 1,
    parameter int unsigned RUN_CYCLES  = 50,
    parameter int unsigned CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] halt_in,
    output logic [NUM_CH-1:0] ch_rst_o,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycle_cnt
);

    localparam int unsigned REL_MAX = (NUM_CH - 1) * STAGGER;
    localparam int unsigned PH_MAX  = (HOLD_CYCLES > REL_MAX) ? HOLD_CYCLES : REL_MAX;
    localparam int unsigned PH_W    = cnt_width(PH_MAX);

    rc_state_e         state, state_nx;
    logic [NUM_CH-1:0] en_q, halted_q, rel_hit;
    logic [PH_W-1:0]   phase_cnt;
    logic              accept, all_halt, run_term, cnt_en;

    always_ff @(posedge clk) begin
        if (!rst) state <= RC_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        all_halt = &(halted_q | halt_in | ~en_q);
        if (abort) begin
            state_nx = RC_IDLE;
        end else begin
            case (state)
                RC_IDLE, RC_DONE: begin
                    if (start && (|ch_en)) begin
                        accept   = 1'b1;
                        state_nx = RC_HOLD;
                    end
                end
                RC_HOLD: begin
                    if (phase_cnt == PH_W'(HOLD_CYCLES - 1)) state_nx = RC_RELEASE;
                end
                RC_RELEASE: begin
                    if (phase_cnt == PH_W'(REL_MAX)) state_nx = RC_RUN;
                end
                RC_RUN: begin
                    if (all_halt || run_term) state_nx = RC_DONE;
                end
                default: state_nx = RC_IDLE;
            endcase
        end
    end

    // phase_cnt times HOLD and RELEASE; it restarts at 0 on every state change
    always_ff @(posedge clk) begin
        if (!rst) begin
            en_q      <= '0;
            halted_q  <= '0;
            done      <= 1'b0;
            timeout   <= 1'b0;
            busy      <= 1'b0;
            phase_cnt <= '0;
        end else begin
            busy <= (state_nx == RC_HOLD) || (state_nx == RC_RELEASE) || (state_nx == RC_RUN);
            if (state_nx != state)
                phase_cnt <= '0;
            else if ((state == RC_HOLD) || (state == RC_RELEASE))
                phase_cnt <= phase_cnt + 1'b1;

            if (abort) begin
                done    <= 1'b0;
                timeout <= 1'b0;
            end else if (accept) begin
                en_q     <= ch_en;
                halted_q <= '0;
                done     <= 1'b0;
                timeout  <= 1'b0;
            end else if (state == RC_RUN) begin
                halted_q <= halted_q | (halt_in & en_q);
                if (state_nx == RC_DONE) begin
                    done    <= all_halt;
                    timeout <= ~all_halt;
                end
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int unsigned REL_AT = i * STAGGER;
        assign rel_hit[i] = (state == RC_RELEASE) && en_q[i] && (phase_cnt == PH_W'(REL_AT));
    end

    // Resets are only ever released while in RELEASE/RUN; any other state forces them back on
    always_ff @(posedge clk) begin
        if (!rst || abort || !((state == RC_RELEASE) || (state == RC_RUN))) begin
            ch_rst_o <= {NUM_CH{RST_ENABLE}};
        end else begin
            for (int unsigned i = 0; i < NUM_CH; i++) begin
                if (rel_hit[i]) ch_rst_o[i] <= RST_DISABLE;
            end
        end
    end

    assign cnt_en = (state == RC_RUN) && !abort;

    run_cycle_counter #(
        .CNT_W    (CNT_W),
        .TERM_EN  (RUN_CYCLES != 0),
        .TERM_VAL ((RUN_CYCLES == 0) ? 0 : RUN_CYCLES - 1)
    ) u_run_cycle_counter (
        .clk  (clk),
        .rst  (rst),
        .clr  (accept),
        .en   (cnt_en),
        .cnt  (cycle_cnt),
        .term (run_term)
    );

endmodule

// File: tb/tb_sopc_run_ctrl.sv
// Self-checking bench for sopc_run_ctrl with default parameters.
module tb_sopc_run_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [1:0]  ch_en = 2'b00;
    logic [1:0]  halt_in = 2'b00;
    logic [1:0]  ch_rst_o;
    logic        busy, done, timeout;
    logic [15:0] cycle_cnt;

    int n_vec = 0;
    int n_err = 0;

    sopc_run_ctrl #(
        .NUM_CH      (2),
        .HOLD_CYCLES (10),
        .STAGGER     (1),
        .RUN_CYCLES  (50),
        .CNT_W       (16)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .ch_en     (ch_en),
        .halt_in   (halt_in),
        .ch_rst_o  (ch_rst_o),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycle_cnt (cycle_cnt)
    );

    always #5 clk = ~clk;

    // Halt/restart times are RUN-cycle indices (cycle where cycle_cnt==j); -100 = never.
    typedef struct {
        logic [1:0] en;
        int         h0;
        int         h1;
        int         restart;
        logic       exp_done;
        logic       exp_to;
        int         exp_cnt;
    } vec_t;

    typedef struct {
        logic done;
        logic to;
        int   cnt;
        int   kend;
    } exp_t;

    exp_t sb[$];

    localparam int NONE   = -100;
    localparam int RUN_K0 = 13;  // edge count (start edge = 1) after which RUN cycle 0 begins

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ch_rst"}, ch_rst_o, 3);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_timeout"}, timeout, 0);
        chk({tag, "_cycle_cnt"}, cycle_cnt, 0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int   k;
        int   rel0, rel1;
        bit   ended;
        exp_t e;
        string tag;
        tag = $sformatf("v%0d", idx);
        rel0 = 0;
        rel1 = 0;
        sb.push_back('{v.exp_done, v.exp_to, v.exp_cnt, RUN_K0 + v.exp_cnt});
        ch_en = v.en;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        chk({tag, "_busy_on_start"}, busy, 1);
        chk({tag, "_flags_cleared"}, {done, timeout}, 0);
        ended = 0;
        while (!ended && k < 150) begin
            halt_in = {(k - RUN_K0) == v.h1, (k - RUN_K0) == v.h0};
            if ((k - RUN_K0) == v.restart) begin
                start = 1'b1;
                ch_en = 2'b01;
            end else begin
                start = 1'b0;
            end
            step();
            k++;
            if (rel0 == 0 && ch_rst_o[0] == 1'b0) rel0 = k;
            if (rel1 == 0 && ch_rst_o[1] == 1'b0) rel1 = k;
            if (done || timeout) ended = 1;
        end
        halt_in = 2'b00;
        start = 1'b0;
        chk({tag, "_end_seen"}, ended, 1);
        if (ended && sb.size() > 0) begin
            e = sb.pop_front();
            chk({tag, "_done"}, done, e.done);
            chk({tag, "_timeout"}, timeout, e.to);
            chk({tag, "_cycle_cnt"}, cycle_cnt, e.cnt);
            chk({tag, "_end_edge"}, k, e.kend);
        end
        chk({tag, "_rel0_edge"}, rel0, v.en[0] ? 12 : 0);
        chk({tag, "_rel1_edge"}, rel1, v.en[1] ? 13 : 0);
        step();
        step();
        chk({tag, "_rst_reasserted"}, ch_rst_o, 3);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_cnt_held"}, cycle_cnt, v.exp_cnt);
    endtask

    initial begin
        vec_t vecs[9];
        int   k;

        vecs[0] = '{2'b11, NONE, NONE, NONE, 1'b0, 1'b1, 50};  // budget expiry
        vecs[1] = '{2'b11,    5,    9, NONE, 1'b1, 1'b0, 10};  // staggered halts
        vecs[2] = '{2'b11,    5,   49, NONE, 1'b1, 1'b0, 50};  // halt and budget same cycle
        vecs[3] = '{2'b01,    7, NONE, NONE, 1'b1, 1'b0,  8};  // ch1 disabled
        vecs[4] = '{2'b01, NONE,    3, NONE, 1'b0, 1'b1, 50};  // halt on disabled channel
        vecs[5] = '{2'b10,    0,    0, NONE, 1'b1, 1'b0,  1};  // only ch1
        vecs[6] = '{2'b11,    0,    0, NONE, 1'b1, 1'b0,  1};  // immediate halt
        vecs[7] = '{2'b01,   -5, NONE, NONE, 1'b0, 1'b1, 50};  // halt during HOLD ignored
        vecs[8] = '{2'b11,   10, NONE,    5, 1'b0, 1'b1, 50};  // start in RUN ignored

        rst = 1'b0;
        step();
        step();
        step();
        chk_reset_vals("reset");
        rst = 1'b1;

        ch_en = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("zero_en_busy", busy, 0);
        step();
        chk("zero_en_ch_rst", ch_rst_o, 3);

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // abort in RELEASE after ch0 released, with a simultaneous start
        ch_en = 2'b11;
        start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        while (k < 12) begin
            step();
            k++;
        end
        chk("abort_pre_ch_rst", ch_rst_o, 2);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_rel_busy", busy, 0);
        chk("abort_rel_ch_rst", ch_rst_o, 3);
        chk("abort_rel_flags", {done, timeout}, 0);
        step();
        step();
        step();
        chk("abort_beats_start", busy, 0);

        // abort in RUN holds cycle_cnt
        start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        while (k < 18) begin
            step();
            k++;
        end
        chk("run5_cycle_cnt", cycle_cnt, 5);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_run_cnt_held", cycle_cnt, 5);
        chk("abort_run_busy", busy, 0);
        chk("abort_run_ch_rst", ch_rst_o, 3);

        // synchronous reset mid-RUN
        start = 1'b1;
        step();
        start = 1'b0;
        k = 1;
        while (k < 20) begin
            step();
            k++;
        end
        chk("pre_rst_busy", busy, 1);
        rst = 1'b0;
        step();
        chk_reset_vals("midrun_rst");
        rst = 1'b1;
        ch_en = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("post_rst_zero_en_busy", busy, 0);
        step();
        chk("post_rst_zero_en_ch_rst", ch_rst_o, 3);

        chk("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
